sign_mag_sub_serial: RTL and testbench
======================================

Name: sign_mag_sub_serial

Overview:
- Bit-serial sign-magnitude subtractor. Computes diff = a - b on (N+1)-bit sign-magnitude words: bit N is the sign, bits N-1:0 are the magnitude.
- Works one magnitude bit per clock, LSB first, under a start/done handshake.
- Gives a low-area alternative to the combinational sign-magnitude adder for the subtract direction. Sits between operand registers and the result bus in the arithmetic datapath.

Parameters:
- N, 4, magnitude width in bits. Words are N+1 bits wide. N >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only while ready=1.
- a  in  N+1  minuend, sign-magnitude. Captured on an accepted start.
- b  in  N+1  subtrahend, sign-magnitude. Captured on an accepted start.
- ready  out  1  high only in IDLE.
- done_tick  out  1  one-cycle pulse when diff/ovf become valid.
- diff  out  N+1  result, sign-magnitude, registered. Held until the next completion.
- ovf  out  1  magnitude overflow of the result, registered. Held like diff.

Behaviour:
- Reset (sync, active-high) values: state=IDLE, ready=1, done_tick=0, diff=0, ovf=0, all internal shift/carry registers=0.
- Reset mid-operation: abort to IDLE on that edge. No done_tick. diff/ovf cleared to 0.
- Operation: sb = ~b[N]. The block performs a sign-magnitude add of a and (sb, b[N-1:0]).
- States: IDLE, OP, NEG, DONE.
- IDLE:
  - ready=1.
  - On start=1: capture a/b magnitudes into shift registers and the signs; clear carry/borrow and the bit counter; go to OP.
  - start=0: stay in IDLE.
- OP (exactly N cycles, counter 0..N-1), one magnitude bit per cycle, LSB first, into the result shift register:
  - a[N]==sb (add path): full add with carry. Final carry-out → ovf=1 and the magnitude is truncated mod 2^N. Result sign = a[N].
  - a[N]!=sb (subtract path): full subtract mag_a - mag_b with borrow. ovf=0 always.
- Leaving OP after bit N-1:
  - Subtract path with final borrow=1: go to NEG. Result sign = sb.
  - Otherwise: go to DONE. Result sign = a[N] (also applies when the magnitudes are equal).
- NEG (exactly N cycles): serial two's-complement of the result magnitude, LSB first. Copy bits up to and including the first 1; invert every bit after it. Then go to DONE.
- DONE (1 cycle):
  - diff <= {sign, mag} and ovf are loaded.
  - done_tick=1 in the cycle diff/ovf are first valid.
  - ready=0.
  - Next state IDLE.
- Latency, counted from the start-sampling edge to the done_tick cycle: N+1 clocks without NEG, 2N+1 with NEG.
  - Back-to-back: a start in the cycle after DONE (IDLE) is accepted.
  - Throughput: one result per N+2 or 2N+2 cycles.
- start while ready=0: ignored. Inputs a/b may change freely after capture without affecting the current operation.
- Sign of zero with the feature disabled: a zero magnitude keeps the computed sign, so -0 (sign=1, mag=0) is possible.
- Add-path overflow: diff holds the truncated magnitude with sign a[N]; ovf=1.

Optional Feature:
- Macro: SIGN_MAG_SUB_ZERO_NORM_EN.
- Defined: when the final magnitude is 0, diff[N] is forced to 0, so the result is always +0. This applies in both add and subtract paths, including an overflow that truncates to 0.
- Undefined: the sign follows the rules above unchanged. No extra logic is instantiated.

Test Plan (all with N=4):
- Negative result: a=00011 (+3), b=00101 (+5), start 1 cycle → NEG path taken; done_tick exactly 9 clocks after the start edge; diff=10010 (-2), ovf=0; ready low for 9 cycles.
- Add path: a=00111 (+7), b=10010 (-2) → done_tick after 5 clocks; diff=01001 (+9), ovf=0.
- Overflow: a=01100 (+12), b=11001 (-9) → diff=00101, ovf=1, done_tick after 5 clocks.
- Equal operands: a=10101 (-5), b=10101 → diff=10000 without the macro, 00000 with SIGN_MAG_SUB_ZERO_NORM_EN; ovf=0; latency 5 clocks.
- Ignore and abort:
  - Pulse start again 2 cycles into an operation → ignored; the first result is unaffected.
  - Assert reset 3 cycles into an operation → next cycle IDLE, ready=1, diff=0, ovf=0, no done_tick.
  - A new start is then accepted normally.
- Back-to-back: issue a new start in the first cycle ready=1 after a done_tick → accepted; the second result is correct and the first diff is held until the second done_tick.

Source files
------------

// File: rtl/sign_mag_sub_serial_if.sv
// Start/done bus for the bit-serial sign-magnitude subtractor; words are N+1 bits.
// Handshake: an operation is accepted on a rising edge where start=1 and ready=1.
// start is ignored while ready=0. done_tick pulses for one cycle when diff/ovf
// are first valid. diff/ovf then hold until the next completion.
interface sign_mag_sub_serial_if #(
  parameter int N = 4
);
  logic         start;
  logic [N:0]   a;
  logic [N:0]   b;
  logic         ready;
  logic         done_tick;
  logic [N:0]   diff;
  logic         ovf;

  modport master (
    output start, a, b,
    input  ready, done_tick, diff, ovf
  );

  modport slave (
    input  start, a, b,
    output ready, done_tick, diff, ovf
  );
endinterface

// File: rtl/sign_mag_sub_serial.sv
// Bit-serial sign-magnitude subtractor: diff = a - b, one magnitude bit per clock, LSB first.
// Optional macro SIGN_MAG_SUB_ZERO_NORM_EN forces a zero-magnitude result to +0.
module sign_mag_sub_serial #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  sign_mag_sub_serial_if.slave  bus,
  output logic [1:0]            fsm_state
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [N-1:0]    sh_a;
  logic [N-1:0]    sh_b;
  logic [N-1:0]    res;
  logic            sa;
  logic            sb;
  logic            cy;
  logic [CW-1:0]   cnt;

  logic            ai;
  logic            bi;
  logic            add_path;
  logic            last;
  logic            op_bit;
  logic            op_cy;
  logic            neg_bit;
  logic            neg_seen;
  logic [N-1:0]    op_mag;
  logic [N-1:0]    neg_mag;
  logic            op_sign;
  logic            neg_sign;

  // cy is the carry (add), the borrow (subtract) or the "first 1 seen" flag (NEG).
  always_comb begin
    ai       = sh_a[0];
    bi       = sh_b[0];
    add_path = (sa == sb);
    last     = (cnt == CW'(N - 1));
    op_bit   = ai ^ bi ^ cy;
    if (add_path) begin
      op_cy = (ai & bi) | (cy & (ai ^ bi));
    end else begin
      op_cy = (~ai & bi) | (~(ai ^ bi) & cy);
    end
    neg_bit  = cy ? ~res[0] : res[0];
    neg_seen = cy | res[0];
    op_mag   = {op_bit, res[N-1:1]};
    neg_mag  = {neg_bit, res[N-1:1]};
    op_sign  = sa;
    neg_sign = sb;
`ifdef SIGN_MAG_SUB_ZERO_NORM_EN
    op_sign  = sa & (|op_mag);
    neg_sign = sb & (|neg_mag);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.ready     <= 1'b1;
      bus.done_tick <= 1'b0;
      bus.diff      <= '0;
      bus.ovf       <= 1'b0;
      sh_a          <= '0;
      sh_b          <= '0;
      res           <= '0;
      sa            <= 1'b0;
      sb            <= 1'b0;
      cy            <= 1'b0;
      cnt           <= '0;
    end else begin
      bus.done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sh_a      <= bus.a[N-1:0];
            sh_b      <= bus.b[N-1:0];
            sa        <= bus.a[N];
            sb        <= ~bus.b[N];
            cy        <= 1'b0;
            cnt       <= '0;
            res       <= '0;
            bus.ready <= 1'b0;
            state     <= OP;
          end
        end
        OP: begin
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          res  <= op_mag;
          cy   <= op_cy;
          cnt  <= cnt + 1'b1;
          if (last) begin
            cnt <= '0;
            // A final borrow means |b| > |a|: the magnitude is in two's complement.
            if (!add_path && op_cy) begin
              cy    <= 1'b0;
              state <= NEG;
            end else begin
              bus.diff      <= {op_sign, op_mag};
              bus.ovf       <= add_path & op_cy;
              bus.done_tick <= 1'b1;
              state         <= DONE;
            end
          end
        end
        NEG: begin
          res <= neg_mag;
          cy  <= neg_seen;
          cnt <= cnt + 1'b1;
          if (last) begin
            cnt           <= '0;
            bus.diff      <= {neg_sign, neg_mag};
            bus.ovf       <= 1'b0;
            bus.done_tick <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_sign_mag_sub_serial.sv
// Directed bench for sign_mag_sub_serial (N=4) with an arithmetic reference model.
module tb_sign_mag_sub_serial;
  localparam int N = 4;
  localparam int W = N + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] fsm_state;

  sign_mag_sub_serial_if #(.N(N)) bus();

  sign_mag_sub_serial #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] exp_q[$];
  logic [N:0]   held_diff = '0;
  logic         held_ovf  = 1'b0;
  logic [W-1:0] cmp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Result as {ovf, sign, magnitude} from plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [N:0] a, input logic [N:0] b);
    int   ma  = int'(a[N-1:0]);
    int   mb  = int'(b[N-1:0]);
    logic sa  = a[N];
    logic sb  = ~b[N];
    int   mag;
    logic s;
    logic o   = 1'b0;
    if (sa == sb) begin
      mag = ma + mb;
      s   = sa;
      if (mag >= (1 << N)) begin
        o   = 1'b1;
        mag = mag - (1 << N);
      end
    end else if (ma >= mb) begin
      mag = ma - mb;
      s   = sa;
    end else begin
      mag = mb - ma;
      s   = sb;
    end
`ifdef SIGN_MAG_SUB_ZERO_NORM_EN
    if (mag == 0) s = 1'b0;
`endif
    return {o, s, mag[N-1:0]};
  endfunction

  function automatic int model_lat(input logic [N:0] a, input logic [N:0] b);
    if ((a[N] != ~b[N]) && (a[N-1:0] < b[N-1:0])) return 2 * N + 1;
    return N + 1;
  endfunction

  // scoreboard: every cycle out of reset, outputs match the last expected result
  always @(posedge clk) begin
    if (reset) begin
      held_diff = '0;
      held_ovf  = 1'b0;
      exp_q.delete();
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done_tick) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("diff", 32'(bus.diff), 32'(cmp_e[N:0]));
          chk("ovf", 32'(bus.ovf), 32'(cmp_e[N+1]));
          held_diff = cmp_e[N:0];
          held_ovf  = cmp_e[N+1];
        end
      end else begin
        chk("diff_held", 32'(bus.diff), 32'(held_diff));
        chk("ovf_held", 32'(bus.ovf), 32'(held_ovf));
      end
    end
  end

  // driver: called #1 after a rising edge; returns in the done_tick cycle
  task automatic do_op(input logic [N:0] av, input logic [N:0] bv, input int poke_at,
                       output logic [N:0] got_diff, output logic got_ovf);
    int lat     = 0;
    int low     = 0;
    int exp_lat = model_lat(av, bv);
    exp_q.push_back(model(av, bv));
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    lat       = 1;
    while (1) begin
      if (!bus.ready) low++;
      bus.start = (lat == poke_at);
      if (bus.done_tick || lat >= 4 * N + 8) break;
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(bus.done_tick), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("ready_low", 32'(low), 32'(exp_lat));
    got_diff = bus.diff;
    got_ovf  = bus.ovf;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("ready_idle", 32'(bus.ready), 32'd1);
  endtask

  logic [N:0] d;
  logic       o;
  logic [N:0] tbl_a[5] = '{5'b11111, 5'b10000, 5'b00000, 5'b01010, 5'b10110};
  logic [N:0] tbl_b[5] = '{5'b00001, 5'b00000, 5'b00000, 5'b00101, 5'b00011};

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done_tick), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    idle_cycle();

    // negative result through NEG: +3 - +5 = -2
    do_op(5'b00011, 5'b00101, 0, d, o);
    chk("neg_diff_lit", 32'(d), 32'b10010);
    chk("neg_ovf_lit", 32'(o), 32'd0);
    idle_cycle();

    // add path: +7 - -2 = +9
    do_op(5'b00111, 5'b10010, 0, d, o);
    chk("add_diff_lit", 32'(d), 32'b01001);
    chk("add_ovf_lit", 32'(o), 32'd0);
    idle_cycle();

    // overflow: +12 - -9 = 21 -> 5 with ovf
    do_op(5'b01100, 5'b11001, 0, d, o);
    chk("ovf_diff_lit", 32'(d), 32'b00101);
    chk("ovf_ovf_lit", 32'(o), 32'd1);
    idle_cycle();

    // equal operands
    do_op(5'b10101, 5'b10101, 0, d, o);
`ifdef SIGN_MAG_SUB_ZERO_NORM_EN
    chk("eq_diff_lit", 32'(d), 32'b00000);
`else
    chk("eq_diff_lit", 32'(d), 32'b10000);
`endif
    chk("eq_ovf_lit", 32'(o), 32'd0);
    idle_cycle();

    // start pulsed while busy is ignored
    do_op(5'b00011, 5'b00101, 2, d, o);
    chk("poke_diff_lit", 32'(d), 32'b10010);
    idle_cycle();

    // reset three cycles into an operation
    exp_q.push_back(model(5'b00111, 5'b10010));
    bus.start = 1'b1;
    bus.a     = 5'b00111;
    bus.b     = 5'b10010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_ready", 32'(bus.ready), 32'd1);
    chk("abort_diff", 32'(bus.diff), 32'd0);
    chk("abort_ovf", 32'(bus.ovf), 32'd0);
    chk("abort_done", 32'(bus.done_tick), 32'd0);
    chk("abort_state", 32'(fsm_state), 32'd0);
    repeat (6) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 32'(bus.done_tick), 32'd0);
    end

    // new start after abort; +15 - -1 wraps to +0 with ovf
    do_op(5'b01111, 5'b10001, 0, d, o);
    chk("wrap_diff_lit", 32'(d), 32'b00000);
    chk("wrap_ovf_lit", 32'(o), 32'd1);
    idle_cycle();

    // back-to-back: second start in the first ready cycle after done
    do_op(5'b00000, 5'b01111, 0, d, o);
    chk("b2b1_diff_lit", 32'(d), 32'b11111);
    idle_cycle();
    do_op(5'b10001, 5'b11111, 0, d, o);
    chk("b2b2_diff_lit", 32'(d), 32'b01110);
    idle_cycle();

    for (int i = 0; i < 5; i++) begin
      do_op(tbl_a[i], tbl_b[i], 0, d, o);
      idle_cycle();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
